// File: rtl/spram_rr_arbiter.sv
// Round-robin front end that shares one single-port, bit-maskable SRAM between NREQ clients.
// Optionally zero-fills the array after reset and supports locked bursts for read-modify-write.
module spram_rr_arbiter #(
  parameter int DW        = 64,
  parameter int AW        = 6,
  parameter int NREQ      = 2,
  parameter int INIT_ZERO = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ-1:0]      req_lock,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  input  logic [NREQ*DW-1:0]   req_wmask,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DW-1:0]        rsp_rdata,
  output logic                 init_done,
  output logic                 mem_ceb,
  output logic                 mem_web,
  output logic [AW-1:0]        mem_a,
  output logic [DW-1:0]        mem_d,
  output logic [DW-1:0]        mem_bweb,
  input  logic [DW-1:0]        mem_q
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW:0] NREQ_P = (PW+1)'(NREQ);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state_reg, state_next;
  logic [AW-1:0]     init_cnt_reg, init_cnt_next;
  logic [PW-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [PW-1:0]     lock_owner_reg, lock_owner_next;
  logic              locked_reg, locked_next;
  logic [NREQ-1:0]   rsp_valid_reg, rsp_valid_next;

  logic [AW-1:0]     addr_arr  [NREQ];
  logic [DW-1:0]     wdata_arr [NREQ];
  logic [DW-1:0]     wmask_arr [NREQ];

  logic              grant_found;
  logic [PW-1:0]     grant_idx;
  logic [PW:0]       cand;
  logic [NREQ-1:0]   ready_vec;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*AW +: AW];
      assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
      assign wmask_arr[gi] = req_wmask[gi*DW +: DW];
    end
  endgenerate

  // A locked owner blocks everyone else even while it has nothing valid.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    ready_vec   = '0;
    if (state_reg == RUN) begin
      if (locked_reg) begin
        grant_found = req_valid[lock_owner_reg];
        grant_idx   = lock_owner_reg;
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          cand = {1'b0, rr_ptr_reg} + (PW+1)'(k);
          if (cand >= NREQ_P) cand = cand - NREQ_P;
          if (!grant_found && req_valid[cand[PW-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[PW-1:0];
          end
        end
      end
      if (grant_found) ready_vec[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    mem_ceb  = 1'b1;
    mem_web  = 1'b1;
    mem_a    = '0;
    mem_d    = '0;
    mem_bweb = '1;
    if (state_reg == INIT) begin
      if (INIT_ZERO != 0) begin
        mem_ceb  = 1'b0;
        mem_web  = 1'b0;
        mem_a    = init_cnt_reg;
        mem_bweb = '0;
      end
    end else if (grant_found) begin
      mem_ceb  = 1'b0;
      mem_web  = ~req_we[grant_idx];
      mem_a    = addr_arr[grant_idx];
      mem_d    = wdata_arr[grant_idx];
      mem_bweb = req_we[grant_idx] ? ~wmask_arr[grant_idx] : '1;
    end
  end

  always_comb begin
    state_next      = state_reg;
    init_cnt_next   = init_cnt_reg;
    rr_ptr_next     = rr_ptr_reg;
    lock_owner_next = lock_owner_reg;
    locked_next     = locked_reg;
    rsp_valid_next  = '0;
    case (state_reg)
      INIT: begin
        init_cnt_next = init_cnt_reg + AW'(1);
        if (INIT_ZERO == 0 || init_cnt_reg == '1) state_next = RUN;
      end
      RUN: begin
        if (grant_found) begin
          if (req_lock[grant_idx]) begin
            locked_next     = 1'b1;
            lock_owner_next = grant_idx;
          end else begin
            locked_next = 1'b0;
            rr_ptr_next = ({1'b0, grant_idx} == NREQ_P - 1'b1) ? '0 : grant_idx + 1'b1;
          end
          if (!req_we[grant_idx]) rsp_valid_next[grant_idx] = 1'b1;
        end
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= INIT;
      init_cnt_reg   <= '0;
      rr_ptr_reg     <= '0;
      lock_owner_reg <= '0;
      locked_reg     <= 1'b0;
      rsp_valid_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      init_cnt_reg   <= init_cnt_next;
      rr_ptr_reg     <= rr_ptr_next;
      lock_owner_reg <= lock_owner_next;
      locked_reg     <= locked_next;
      rsp_valid_reg  <= rsp_valid_next;
    end
  end

  assign req_ready = ready_vec;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = mem_q;
  assign init_done = (state_reg == RUN);

endmodule

// File: tb/tb_spram_rr_arbiter.sv
// Directed bench for spram_rr_arbiter with a behavioural bit-maskable single-port RAM attached.
module tb_spram_rr_arbiter;

  localparam int DW = 64;
  localparam int AW = 6;
  localparam int NREQ = 2;

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_we;
  logic [NREQ-1:0]      req_lock;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [NREQ*DW-1:0]   req_wmask;
  logic [NREQ-1:0]      rsp_valid;
  logic [DW-1:0]        rsp_rdata;
  logic                 init_done;
  logic                 mem_ceb;
  logic                 mem_web;
  logic [AW-1:0]        mem_a;
  logic [DW-1:0]        mem_d;
  logic [DW-1:0]        mem_bweb;
  logic [DW-1:0]        mem_q;

  int checks = 0;
  int errors = 0;

  spram_rr_arbiter #(.DW(DW), .AW(AW), .NREQ(NREQ), .INIT_ZERO(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
    .mem_ceb(mem_ceb), .mem_web(mem_web), .mem_a(mem_a), .mem_d(mem_d),
    .mem_bweb(mem_bweb), .mem_q(mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: active-low controls, registered read data, read-old-data semantics.
  logic [DW-1:0] ram [1<<AW];
  logic [DW-1:0] q_reg;
  always @(posedge clk) begin
    if (!mem_ceb) begin
      if (!mem_web) ram[mem_a] <= (ram[mem_a] & mem_bweb) | (mem_d & ~mem_bweb);
      else          q_reg <= ram[mem_a];
    end
  end
  assign mem_q = q_reg;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic we, input logic lk,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
    req_valid[i] = v;
    req_we[i] = we;
    req_lock[i] = lk;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_wmask[i*DW +: DW] = m;
  endtask

  task automatic idle(input int i);
    set_req(i, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0; req_we = '0; req_lock = '0;
    req_addr = '0; req_wdata = '0; req_wmask = '0;
    q_reg = '0;
    for (int i = 0; i < (1 << AW); i++) ram[i] = 64'hDEAD_BEEF_0000_0000 | 64'(i);

    repeat (3) @(negedge clk);
    set_req(0, 1'b1, 1'b0, 1'b0, 6'd9, '0, '0);
    #1;
    chk("rst_init_done", init_done, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_ready", req_ready, 0);
    idle(0);
    reset = 1'b0;
    #1;

    // Zero-fill walks every address once.
    for (int c = 0; c < 64; c++) begin
      chk("init_mem_a", mem_a, 64'(c));
      chk("init_ceb", mem_ceb, 0);
      chk("init_web", mem_web, 0);
      chk("init_bweb", mem_bweb, 0);
      chk("init_done_low", init_done, 0);
      tick;
    end
    chk("init_done_rise", init_done, 1);

    set_req(0, 1'b1, 1'b0, 1'b0, 6'd17, '0, '0);
    #1;
    chk("rd17_ready", req_ready, 2'b01);
    chk("rd17_ceb", mem_ceb, 0);
    chk("rd17_web", mem_web, 1);
    chk("rd17_a", mem_a, 17);
    chk("rd17_bweb", mem_bweb, 64'hFFFF_FFFF_FFFF_FFFF);
    tick;
    chk("rd17_rsp_valid", rsp_valid, 2'b01);
    chk("rd17_rsp_data", rsp_rdata, 0);

    // Preload addr1 from req0 and addr2 from req1; leaves rr_ptr at 0.
    set_req(0, 1'b1, 1'b1, 1'b0, 6'd1, 64'h1111, '1);
    #1;
    chk("pre1_ready", req_ready, 2'b01);
    tick;
    chk("pre1_no_rsp", rsp_valid, 0);
    idle(0);
    set_req(1, 1'b1, 1'b1, 1'b0, 6'd2, 64'h2222, '1);
    #1;
    chk("pre2_ready", req_ready, 2'b10);
    tick;
    chk("pre2_no_rsp", rsp_valid, 0);

    set_req(0, 1'b1, 1'b0, 1'b0, 6'd1, '0, '0);
    set_req(1, 1'b1, 1'b0, 1'b0, 6'd2, '0, '0);
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("alt_ready", req_ready, (j % 2 == 0) ? 64'd1 : 64'd2);
      tick;
      chk("alt_rsp_valid", rsp_valid, (j % 2 == 0) ? 64'd1 : 64'd2);
      chk("alt_rsp_data", rsp_rdata, (j % 2 == 0) ? 64'h1111 : 64'h2222);
    end
    idle(0);
    idle(1);

    set_req(0, 1'b1, 1'b1, 1'b0, 6'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF);
    #1;
    chk("mask_bweb", mem_bweb, 64'hFFFF_FFFF_0000_0000);
    chk("mask_web", mem_web, 0);
    chk("mask_d", mem_d, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("mask_a", mem_a, 5);
    tick;
    set_req(0, 1'b1, 1'b0, 1'b0, 6'd5, '0, '0);
    #1;
    chk("mask_rd_ready", req_ready, 2'b01);
    tick;
    chk("mask_rsp_valid", rsp_valid, 2'b01);
    chk("mask_rsp_data", rsp_rdata, 64'h0000_0000_FFFF_FFFF);
    idle(0);

    // req1 alone moves rr_ptr back to 0 before the lock burst.
    set_req(1, 1'b1, 1'b0, 1'b0, 6'd2, '0, '0);
    #1;
    chk("r1_ready", req_ready, 2'b10);
    tick;
    chk("r1_rsp_data", rsp_rdata, 64'h2222);

    set_req(1, 1'b1, 1'b0, 1'b0, 6'd1, '0, '0);
    for (int j = 0; j < 3; j++) begin
      set_req(0, 1'b1, 1'b1, (j < 2), 6'(10 + j), 64'(100 + j), '1);
      #1;
      chk("lock_ready", req_ready, 2'b01);
      tick;
      chk("lock_no_rsp", rsp_valid, 0);
    end
    idle(0);
    #1;
    chk("unlock_ready", req_ready, 2'b10);
    tick;
    chk("unlock_rsp_valid", rsp_valid, 2'b10);
    chk("unlock_rsp_data", rsp_rdata, 64'h1111);

    // Owner idle while locked still blocks req1.
    set_req(0, 1'b1, 1'b1, 1'b1, 6'd20, 64'h20, '1);
    #1;
    chk("lkidle_take", req_ready, 2'b01);
    tick;
    idle(0);
    #1;
    chk("lkidle_block", req_ready, 2'b00);
    tick;
    set_req(0, 1'b1, 1'b1, 1'b0, 6'd21, 64'h21, '1);
    #1;
    chk("lkidle_release", req_ready, 2'b01);
    tick;
    idle(0);
    #1;
    chk("lkidle_r1", req_ready, 2'b10);
    tick;
    idle(1);

    // Write then read of the same address sees new data.
    set_req(0, 1'b1, 1'b1, 1'b0, 6'd3, 64'hA5, '1);
    tick;
    set_req(0, 1'b1, 1'b0, 1'b0, 6'd3, '0, '0);
    tick;
    chk("wr_rd_valid", rsp_valid, 2'b01);
    chk("wr_rd_data", rsp_rdata, 64'hA5);
    // Read then write of the same address sees old data.
    tick;
    set_req(0, 1'b1, 1'b1, 1'b0, 6'd3, 64'h5A, '1);
    #1;
    chk("rd_wr_valid", rsp_valid, 2'b01);
    chk("rd_wr_data", rsp_rdata, 64'hA5);
    tick;
    set_req(0, 1'b1, 1'b0, 1'b0, 6'd3, '0, '0);
    tick;
    chk("rd_after_wr_data", rsp_rdata, 64'h5A);

    // Reset while locked with a read in flight.
    set_req(0, 1'b1, 1'b1, 1'b1, 6'd3, 64'h77, '1);
    tick;
    set_req(0, 1'b1, 1'b0, 1'b1, 6'd3, '0, '0);
    reset = 1'b1;
    tick;
    chk("mrst_rsp_valid", rsp_valid, 0);
    chk("mrst_init_done", init_done, 0);
    chk("mrst_ready", req_ready, 0);
    chk("mrst_mem_a", mem_a, 0);
    chk("mrst_web", mem_web, 0);
    reset = 1'b0;
    idle(0);
    repeat (64) tick;
    chk("mrst_init_done_rise", init_done, 1);
    set_req(1, 1'b1, 1'b0, 1'b0, 6'd3, '0, '0);
    #1;
    chk("mrst_lock_cleared", req_ready, 2'b10);
    tick;
    chk("mrst_rezero_valid", rsp_valid, 2'b10);
    chk("mrst_rezero_data", rsp_rdata, 0);
    idle(1);
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spram_rr_arbiter.md
Name: spram_rr_arbiter

Overview:
- Round-robin controller that shares one single-port bit-maskable SRAM macro between NREQ requesters. The macro is a la_spram-backed ram1p1rwbe_* wrapper with active-low CEB/WEB/BWEB.
- Sits between cache/table clients and the RAM wrapper.
- Optionally zero-fills the array after reset.
- Supports locked multi-transaction bursts for read-modify-write sequences.

Parameters:
- DW, 64, data width (must match RAM wrapper).
- AW, 6, address width; depth = 2^AW.
- NREQ, 2, number of requesters (>=1).
- INIT_ZERO, 1, 1 = zero-fill all entries after reset before serving requests.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester grant/accept
- req_we  in  NREQ  1 = write, 0 = read
- req_lock  in  NREQ  hold grant after this transaction
- req_addr  in  NREQ*AW  address, requester i at [i*AW +: AW]
- req_wdata  in  NREQ*DW  write data, slice as above
- req_wmask  in  NREQ*DW  active-high bit write enables
- rsp_valid  out  NREQ  one-hot read-data valid
- rsp_rdata  out  DW  read data (mem_q passthrough)
- init_done  out  1  high once array is usable
- mem_ceb  out  1  RAM chip enable, active-low
- mem_web  out  1  RAM write enable, active-low
- mem_a  out  AW  RAM address
- mem_d  out  DW  RAM write data
- mem_bweb  out  DW  RAM bit write enable, active-low
- mem_q  in  DW  RAM read data, valid 1 cycle after read access

Behaviour:
- FSM states: INIT, RUN. Reset forces INIT with init counter = 0, rr_ptr = 0, locked = 0, rsp_valid = 0, init_done = 0.
- INIT with INIT_ZERO=1:
  - Each cycle drives mem_ceb=0, mem_web=0, mem_a=counter, mem_d=0, mem_bweb=all 0.
  - Counter increments each cycle. After writing address 2^AW-1, the next state is RUN.
  - INIT therefore lasts 2^AW cycles.
- INIT with INIT_ZERO=0: INIT lasts exactly 1 cycle with mem_ceb=1.
- init_done = (state==RUN). req_ready = 0 in INIT.
- Idle memory drive (RUN, no accept): mem_ceb=1, mem_web=1, mem_a=0, mem_d=0, mem_bweb=all 1.
- Arbitration (RUN, combinational):
  - If unlocked, the grant goes to the first i with req_valid[i], scanning cyclically from rr_ptr.
  - If locked, only lock_owner may be granted. Other requesters see ready=0 even when the owner is idle.
  - req_ready = one-hot grant. ready may depend on valid; requesters must not make valid depend on ready.
- Accept = valid & ready. Same cycle the memory is driven with:
  - mem_ceb=0, mem_web=~req_we, mem_a=addr, mem_d=wdata.
  - mem_bweb=~wmask for writes, all 1 for reads.
- Pointer and lock update on accept:
  - If req_lock=1: locked<=1, lock_owner<=grant, rr_ptr unchanged.
  - Else: locked<=0, rr_ptr<=(grant+1) mod NREQ.
  - No lock timeout; the owner must release it.
- Read response:
  - rsp_valid[i] is registered and asserts exactly 1 cycle after a read accept for i; otherwise 0.
  - rsp_rdata = mem_q in all cycles.
  - No response backpressure; requesters must sample on rsp_valid.
  - Writes produce no response.
- Throughput: 1 access/cycle. Read latency: accept cycle + 1.
- Ordering:
  - Write at t then read of the same address at t+1 returns the new data.
  - Read at t then write at t+1 returns the old data.
- Reset mid-operation (any cycle):
  - Pending rsp_valid is dropped next cycle and the lock is cleared.
  - INIT restarts, re-zeroing the array if INIT_ZERO=1.
- NREQ=1: rr_ptr is a 1-bit constant 0 and lock is a no-op for fairness.

Test Plan:
- DW=64, AW=6, INIT_ZERO=1; release reset:
  - mem_a steps 0..63 with mem_web=0 and mem_bweb=0 for 64 cycles.
  - init_done rises on cycle 65.
  - A subsequent read of addr 17 returns 0.
- Both requesters continuously issue reads (addr 1 / addr 2) -> grants alternate 0,1,0,1.
  - rsp_valid = 01,10,01,10 one cycle later, with matching data.
- Req0 writes addr 5 data 0xFFFF_FFFF_FFFF_FFFF, wmask 0x0000_0000_FFFF_FFFF -> mem_bweb = 0xFFFF_FFFF_0000_0000.
  - A read of addr 5 then returns 0x0000_0000_FFFF_FFFF.
- Req0 issues 3 writes with lock=1,1,0 while req1 is valid -> req1 ready=0 for those 3 cycles; req1 is granted on the 4th cycle.
- Write addr 3=0xA5 at t, read addr 3 at t+1 -> rsp 0xA5 at t+2.
  - Read addr 3 at t, write 0x5A at t+1 -> rsp 0xA5.
- Assert reset while locked and with a read response pending -> rsp_valid=0 and init_done=0 next cycle; INIT restarts at mem_a=0.
